twiddle_stage_sequencer: RTL and testbench

//   Upstream feeder for the twiddle factor generator. Holds the D forward and D inverse

---
 rtl/twiddle_stage_sequencer_pkg.sv | 25 ++
 rtl/twiddle_stage_sequencer_bank.sv | 27 ++
 rtl/twiddle_stage_sequencer.sv | 119 +++++++++++
 tb/tb_twiddle_stage_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_stage_sequencer_pkg.sv
// Shared definitions for the twiddle stage sequencer: FSM encoding,
// stage-count helpers and the packed-vector word-slice macro.
`ifndef TWIDDLE_WORD
`define TWIDDLE_WORD(vec, i, n) vec[(i)*(n) +: (n)]
`endif

package twiddle_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Number of NTT stages for a vector of d twiddles.
  function automatic int stage_count(input int d);
    return $clog2(d);
  endfunction

  // Bits needed to index s stages; never narrower than one bit.
  function automatic int stage_width(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/twiddle_stage_sequencer_bank.sv
// D x N twiddle register file: one write port, whole bank read out packed,
// asynchronously cleared to zero.
module twiddle_bank
  import twiddle_stage_sequencer_pkg::*;
#(
  parameter int N = 17,
  parameter int D = 8,
  localparam int IW = $clog2(D)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [IW-1:0]  wr_idx,
  input  logic [N-1:0]   wr_data,
  output logic [N*D-1:0] words
);

  // Single addressed word write; all other words hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words <= '0;
    end else if (wr_en) begin
      `TWIDDLE_WORD(words, wr_idx, N) <= wr_data;
    end
  end

endmodule

// File: rtl/twiddle_stage_sequencer.sv
// Twiddle stage sequencer: holds forward/inverse base twiddle banks loaded
// by the host and, on start, walks the log2(D) NTT stages with a
// valid/ready handshake toward the twiddle factor generator.
module twiddle_stage_sequencer
  import twiddle_stage_sequencer_pkg::*;
#(
  parameter  int N  = 17,
  parameter  int D  = 8,
  localparam int S  = stage_count(D),
  localparam int SW = stage_width(S),
  localparam int IW = $clog2(D)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic           load_inv,
  input  logic [IW-1:0]  load_idx,
  input  logic [N-1:0]   load_data,
  input  logic           start,
  input  logic           inv_req,
  input  logic           ready,
  output logic           valid,
  output logic [N*D-1:0] tf_in,
  output logic [N*D-1:0] tf_in_inv,
  output logic           inv,
  output logic [SW-1:0]  stage,
  output logic           last,
  output logic           busy,
  output logic           done
);

  localparam logic [SW-1:0] STAGE_LAST = SW'(S - 1);

  seq_state_t state;
  logic       fwd_we;
  logic       inv_we;

  // Banks are writable only while idle so a sweep always sees stable words.
  always_comb begin
    fwd_we = 1'b0;
    inv_we = 1'b0;
    if (state == ST_IDLE && load_en) begin
      fwd_we = !load_inv;
      inv_we = load_inv;
    end
  end

  twiddle_bank #(.N(N), .D(D)) u_fwd_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fwd_we),
    .wr_idx  (load_idx),
    .wr_data (load_data),
    .words   (tf_in)
  );

  twiddle_bank #(.N(N), .D(D)) u_inv_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inv_we),
    .wr_idx  (load_idx),
    .wr_data (load_data),
    .words   (tf_in_inv)
  );

  // Sweep FSM with stage counter; every output is a register.
  // last is precomputed from the next stage value so it stays registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      valid <= 1'b0;
      inv   <= 1'b0;
      stage <= '0;
      last  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && !load_en) begin
            inv   <= inv_req;
            stage <= '0;
            valid <= 1'b1;
            last  <= (STAGE_LAST == '0);
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (ready) begin
            if (stage == STAGE_LAST) begin
              valid <= 1'b0;
              last  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              stage <= stage + SW'(1);
              last  <= ((stage + SW'(1)) == STAGE_LAST);
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          valid <= 1'b0;
          last  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_stage_sequencer.sv
// Directed self-checking bench for twiddle_stage_sequencer (N=17, D=8).
module tb_twiddle_stage_sequencer;

  localparam int N  = 17;
  localparam int D  = 8;
  localparam int W  = N * D;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic          load_inv;
  logic [2:0]    load_idx;
  logic [N-1:0]  load_data;
  logic          start;
  logic          inv_req;
  logic          ready;
  logic          valid;
  logic [W-1:0]  tf_in;
  logic [W-1:0]  tf_in_inv;
  logic          inv;
  logic [SW-1:0] stage;
  logic          last;
  logic          busy;
  logic          done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [W-1:0]  exp_fwd;
  logic [W-1:0]  exp_inv;
  logic [W-1:0]  snap_fwd;
  logic [SW-1:0] snap_stage;
  logic [N-1:0]  word;

  twiddle_stage_sequencer #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_inv  (load_inv),
    .load_idx  (load_idx),
    .load_data (load_data),
    .start     (start),
    .inv_req   (inv_req),
    .ready     (ready),
    .valid     (valid),
    .tf_in     (tf_in),
    .tf_in_inv (tf_in_inv),
    .inv       (inv),
    .stage     (stage),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check(tag, W'(busy), W'(0));
  endtask

  initial begin
    int unsigned rise_cnt;
    int unsigned rise_at [2];
    logic        prev_valid;
    int          exp_stage;

    rst = 1'b1; load_en = 1'b0; load_inv = 1'b0; load_idx = '0; load_data = '0;
    start = 1'b0; inv_req = 1'b0; ready = 1'b0;
    exp_fwd = '0; exp_inv = '0;
    step();
    check("rst_valid", W'(valid), W'(0));
    check("rst_busy",  W'(busy),  W'(0));
    check("rst_stage", W'(stage), W'(0));
    check("rst_done",  W'(done),  W'(0));
    check("rst_last",  W'(last),  W'(0));
    check("rst_inv",   W'(inv),   W'(0));
    check("rst_fwd",   tf_in,     W'(0));
    check("rst_invb",  tf_in_inv, W'(0));
    rst = 1'b0;
    step();

    // Load both banks.
    for (int i = 0; i < D; i++) begin
      load_en = 1'b1; load_inv = 1'b0; load_idx = 3'(i); load_data = N'(i + 1);
      exp_fwd[i*N +: N] = N'(i + 1);
      step();
    end
    for (int i = 0; i < D; i++) begin
      load_en = 1'b1; load_inv = 1'b1; load_idx = 3'(i); load_data = N'(17'h10000 - i);
      exp_inv[i*N +: N] = N'(17'h10000 - i);
      step();
    end
    load_en = 1'b0;
    word = tf_in[16:0];
    check("load_w0", W'(word), W'(1));
    word = tf_in[135:119];
    check("load_w7", W'(word), W'(8));
    word = tf_in_inv[33:17];
    check("load_inv_w1", W'(word), W'(17'h0FFFF));
    check("load_fwd_all", tf_in, exp_fwd);
    check("load_inv_all", tf_in_inv, exp_inv);
    check("load_no_valid", W'(valid), W'(0));

    // Forward sweep, ready high.
    ready = 1'b1; inv_req = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("fwd_valid", W'(valid), W'(1));
      check("fwd_stage", W'(stage), W'(s));
      check("fwd_last",  W'(last),  W'(s == 2));
      check("fwd_inv",   W'(inv),   W'(0));
      check("fwd_busy",  W'(busy),  W'(1));
      check("fwd_done0", W'(done),  W'(0));
      step();
    end
    check("fwd_done",       W'(done),  W'(1));
    check("fwd_done_valid", W'(valid), W'(0));
    check("fwd_done_stage", W'(stage), W'(2));
    check("fwd_done_busy",  W'(busy),  W'(1));
    step();
    check("fwd_idle_busy", W'(busy), W'(0));
    check("fwd_idle_done", W'(done), W'(0));

    // Backpressure sweep, inverse direction.
    inv_req = 1'b1; ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp_stage = 0;
    foreach (rise_at[k]) rise_at[k] = 0;
    begin
      logic rdy_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 6; k++) begin
        check("bp_valid", W'(valid), W'(1));
        check("bp_inv",   W'(inv),   W'(1));
        check("bp_stage", W'(stage), W'(exp_stage));
        snap_fwd = tf_in; snap_stage = stage;
        ready = rdy_seq[k];
        step();
        if (rdy_seq[k]) begin
          exp_stage++;
        end else begin
          check("bp_hold_stage", W'(stage), W'(snap_stage));
          check("bp_hold_tf",    tf_in,     snap_fwd);
          check("bp_hold_valid", W'(valid), W'(1));
        end
      end
    end
    check("bp_done", W'(done), W'(1));
    check("bp_done_inv", W'(inv), W'(1));
    step();
    check("bp_idle", W'(busy), W'(0));

    // Start colliding with a load in IDLE: load wins.
    start = 1'b1; load_en = 1'b1; load_inv = 1'b0; load_idx = 3'd3; load_data = 17'h1ABCD;
    exp_fwd[3*N +: N] = 17'h1ABCD;
    step();
    start = 1'b0; load_en = 1'b0;
    check("col_valid", W'(valid), W'(0));
    check("col_busy",  W'(busy),  W'(0));
    check("col_load",  tf_in,     exp_fwd);

    // Load and start during RUN are ignored.
    ready = 1'b1; inv_req = 1'b0; start = 1'b1;
    step();
    load_en = 1'b1; load_inv = 1'b0; load_idx = 3'd0; load_data = 17'h15555;
    check("run_stage0", W'(stage), W'(0));
    step();
    check("run_stage1", W'(stage), W'(1));
    step();
    check("run_stage2", W'(stage), W'(2));
    start = 1'b0; load_en = 1'b1; load_inv = 1'b1;
    step();
    load_en = 1'b0;
    check("run_done", W'(done), W'(1));
    step();
    check("run_idle",     W'(busy),  W'(0));
    check("run_fwd_kept", tf_in,     exp_fwd);
    check("run_inv_kept", tf_in_inv, exp_inv);

    // Back-to-back: start held high, measure start-to-start period.
    ready = 1'b1; start = 1'b1;
    rise_cnt = 0; prev_valid = valid;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (valid && !prev_valid && rise_cnt < 2) begin
        rise_at[rise_cnt] = c;
        rise_cnt++;
      end
      prev_valid = valid;
    end
    start = 1'b0;
    check("b2b_rises",  W'(rise_cnt),  W'(2));
    check("b2b_first",  W'(rise_at[0]), W'(1));
    check("b2b_period", W'(rise_at[1] - rise_at[0]), W'(5));
    wait_idle("b2b_idle_timeout");

    // Asynchronous reset mid-RUN at stage 1.
    ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    ready = 1'b0;
    check("pre_rst_stage", W'(stage), W'(1));
    rst = 1'b1;
    #1;
    check("arst_valid", W'(valid),   W'(0));
    check("arst_busy",  W'(busy),    W'(0));
    check("arst_stage", W'(stage),   W'(0));
    check("arst_fwd",   tf_in,       W'(0));
    check("arst_inv",   tf_in_inv,   W'(0));
    check("arst_done",  W'(done),    W'(0));
    step();
    rst = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("arst_no_done", W'(done),  W'(0));
      check("arst_no_valid", W'(valid), W'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
